// File: rtl/tile_mm_arbiter.sv
// tile_mm_arbiter: round-robin arbiter sharing one tile mm_* port among NUM_REQ requesters.
// Supports lock (back-to-back ownership) and a per-transaction timeout that forces an
// error completion.
// Ports:
//   clock, reset_n                   clock and async active-low reset
//   req_valid/write/lock [NUM_REQ]   per-requester request, direction, keep-grant
//   req_addr, req_wdata              packed per-requester fields, requester i at slice i
//   req_ready, req_error [NUM_REQ]   one-hot completion pulse, timeout flag
//   req_rdata                        read data, valid with req_ready
//   mm_valid/write/addr/wdata        tile-side transaction, held until ack
//   mm_rdata, mm_ready               tile read data and acknowledge
//   grant_id, busy, error_count      status: last grant, not idle, saturating timeouts
module tile_mm_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned ADDR_WIDTH     = 12,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_REQ-1:0]            req_lock,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            req_error,
    output logic [DATA_WIDTH-1:0]         req_rdata,
    output logic                          mm_valid,
    output logic                          mm_write,
    output logic [ADDR_WIDTH-1:0]         mm_addr,
    output logic [DATA_WIDTH-1:0]         mm_wdata,
    input  logic [DATA_WIDTH-1:0]         mm_rdata,
    input  logic                          mm_ready,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy,
    output logic [7:0]                    error_count
);

    localparam int unsigned GW = $clog2(NUM_REQ);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_RECOVER
    } state_t;

    state_t                 state_q, state_d;
    logic                   mm_valid_q, mm_valid_d;
    logic                   mm_write_q, mm_write_d;
    logic [ADDR_WIDTH-1:0]  mm_addr_q, mm_addr_d;
    logic [DATA_WIDTH-1:0]  mm_wdata_q, mm_wdata_d;
    logic [NUM_REQ-1:0]     req_ready_q, req_ready_d;
    logic [NUM_REQ-1:0]     req_error_q, req_error_d;
    logic [DATA_WIDTH-1:0]  req_rdata_q, req_rdata_d;
    logic [GW-1:0]          grant_q, grant_d;
    logic [GW-1:0]          last_q, last_d;
    logic                   lock_q, lock_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic                   busy_q, busy_d;
    logic [7:0]             err_cnt_q, err_cnt_d;

    logic [GW-1:0]          win;
    logic                   win_found;
    logic [GW-1:0]          cand;

    // Winner selection, next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        mm_valid_d  = mm_valid_q;
        mm_write_d  = mm_write_q;
        mm_addr_d   = mm_addr_q;
        mm_wdata_d  = mm_wdata_q;
        req_ready_d = '0;
        req_error_d = '0;
        req_rdata_d = req_rdata_q;
        grant_d     = grant_q;
        last_d      = last_q;
        lock_d      = lock_q;
        timer_d     = timer_q;
        err_cnt_d   = err_cnt_q;
        win         = grant_q;
        win_found   = 1'b0;
        cand        = '0;

        // Locked owner keeps the port; otherwise search upward from last_grant+1
        if (lock_q && req_valid[grant_q]) begin
            win       = grant_q;
            win_found = 1'b1;
        end else begin
            for (int unsigned k = 1; k <= NUM_REQ; k++) begin
                cand = GW'((32'(last_q) + k) % NUM_REQ);
                if (!win_found && req_valid[cand]) begin
                    win       = cand;
                    win_found = 1'b1;
                end
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    mm_valid_d = 1'b1;
                    mm_write_d = req_write[win];
                    mm_addr_d  = req_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
                    mm_wdata_d = req_wdata[win*DATA_WIDTH +: DATA_WIDTH];
                    grant_d    = win;
                    last_d     = win;
                    lock_d     = 1'b0;
                    timer_d    = '0;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // An ack on the timeout edge wins: normal completion
                if (mm_ready) begin
                    req_rdata_d          = mm_rdata;
                    req_ready_d[grant_q] = 1'b1;
                    mm_valid_d           = 1'b0;
                    lock_d               = req_lock[grant_q];
                    state_d              = ST_RECOVER;
                end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    req_rdata_d          = '0;
                    req_ready_d[grant_q] = 1'b1;
                    req_error_d[grant_q] = 1'b1;
                    mm_valid_d           = 1'b0;
                    lock_d               = 1'b0;
                    if (err_cnt_q != 8'hFF) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                    state_d              = ST_RECOVER;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_RECOVER: begin
                // Tile ack lags mm_valid by a cycle; ignore it here
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            mm_valid_q  <= 1'b0;
            mm_write_q  <= 1'b0;
            mm_addr_q   <= '0;
            mm_wdata_q  <= '0;
            req_ready_q <= '0;
            req_error_q <= '0;
            req_rdata_q <= '0;
            grant_q     <= '0;
            last_q      <= GW'(NUM_REQ - 1);
            lock_q      <= 1'b0;
            timer_q     <= '0;
            busy_q      <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            mm_valid_q  <= mm_valid_d;
            mm_write_q  <= mm_write_d;
            mm_addr_q   <= mm_addr_d;
            mm_wdata_q  <= mm_wdata_d;
            req_ready_q <= req_ready_d;
            req_error_q <= req_error_d;
            req_rdata_q <= req_rdata_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            lock_q      <= lock_d;
            timer_q     <= timer_d;
            busy_q      <= busy_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign mm_valid    = mm_valid_q;
    assign mm_write    = mm_write_q;
    assign mm_addr     = mm_addr_q;
    assign mm_wdata    = mm_wdata_q;
    assign req_ready   = req_ready_q;
    assign req_error   = req_error_q;
    assign req_rdata   = req_rdata_q;
    assign grant_id    = grant_q;
    assign busy        = busy_q;
    assign error_count = err_cnt_q;

endmodule

// File: tb/tb_tile_mm_arbiter.sv
// Directed bench for tile_mm_arbiter (NUM_REQ=4, TIMEOUT_CYCLES=8).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_tile_mm_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned AW = 12;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 8;

    logic              clock;
    logic              reset_n;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_write;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR-1:0]     req_lock;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     req_error;
    logic [DW-1:0]     req_rdata;
    logic              mm_valid;
    logic              mm_write;
    logic [AW-1:0]     mm_addr;
    logic [DW-1:0]     mm_wdata;
    logic [DW-1:0]     mm_rdata;
    logic              mm_ready;
    logic [1:0]        grant_id;
    logic              busy;
    logic [7:0]        error_count;

    logic auto_ack;
    logic man_ready;
    logic ack_q;

    int n_checks;
    int n_pass;
    int gap;

    tile_mm_arbiter #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_lock(req_lock),
        .req_ready(req_ready), .req_error(req_error), .req_rdata(req_rdata),
        .mm_valid(mm_valid), .mm_write(mm_write), .mm_addr(mm_addr),
        .mm_wdata(mm_wdata), .mm_rdata(mm_rdata), .mm_ready(mm_ready),
        .grant_id(grant_id), .busy(busy), .error_count(error_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Tile model: in auto mode, ack one cycle after mm_valid rises
    assign mm_ready = auto_ack ? ack_q : man_ready;
    always @(posedge clock) ack_q <= auto_ack && mm_valid && !ack_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Cycles from one mm_valid rise to the next (bounded at 20)
    task automatic next_grant(output int n);
        n = 0;
        while (mm_valid === 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        while (mm_valid !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        reset_n   = 1'b0;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_lock  = '0;
        mm_rdata  = '0;
        auto_ack  = 1'b0;
        man_ready = 1'b0;

        // Reset state
        cyc(2);
        check("rst_mm_valid", 32'(mm_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant", 32'(grant_id), 32'd0);
        check("rst_errcnt", 32'(error_count), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_mm_addr", 32'(mm_addr), 32'd0);
        reset_n = 1'b1;

        // Requester 2 write, ack one cycle after mm_valid
        req_valid = 4'b0100;
        req_write = 4'b0100;
        req_addr[2*AW +: AW]  = 12'h400;
        req_wdata[2*DW +: DW] = 32'hDEADBEEF;
        cyc(1);
        check("wr_mm_valid", 32'(mm_valid), 32'd1);
        check("wr_mm_write", 32'(mm_write), 32'd1);
        check("wr_mm_addr", 32'(mm_addr), 32'h400);
        check("wr_mm_wdata", mm_wdata, 32'hDEADBEEF);
        check("wr_grant", 32'(grant_id), 32'd2);
        check("wr_busy", 32'(busy), 32'd1);
        cyc(1);
        check("wr_ready_early", 32'(req_ready), 32'd0);
        man_ready = 1'b1;
        cyc(1);
        check("wr_ready", 32'(req_ready), 32'b0100);
        check("wr_error", 32'(req_error), 32'd0);
        check("wr_mm_valid_drop", 32'(mm_valid), 32'd0);
        req_valid = '0;
        man_ready = 1'b0;
        cyc(1);
        check("wr_ready_clear", 32'(req_ready), 32'd0);
        check("wr_busy_low", 32'(busy), 32'd0);

        // Requester 0 read
        req_valid = 4'b0001;
        req_write = '0;
        req_addr[0 +: AW] = 12'h010;
        mm_rdata = 32'h12345678;
        cyc(1);
        check("rd_grant", 32'(grant_id), 32'd0);
        check("rd_mm_write", 32'(mm_write), 32'd0);
        cyc(1);
        man_ready = 1'b1;
        cyc(1);
        check("rd_ready", 32'(req_ready), 32'b0001);
        check("rd_rdata", req_rdata, 32'h12345678);
        check("rd_error", 32'(req_error), 32'd0);
        req_valid = '0;
        man_ready = 1'b0;
        cyc(1);

        // Requester 3 with lock, tile never acks: timeout on the 8th ISSUE edge
        req_valid = 4'b1000;
        req_lock  = 4'b1000;
        req_addr[3*AW +: AW] = 12'h0FC;
        mm_rdata = 32'hAAAA5555;
        cyc(1);
        check("to_grant", 32'(grant_id), 32'd3);
        cyc(7);
        check("to_ready_early", 32'(req_ready), 32'd0);
        check("to_busy", 32'(busy), 32'd1);
        cyc(1);
        check("to_ready", 32'(req_ready), 32'b1000);
        check("to_error", 32'(req_error), 32'b1000);
        check("to_rdata", req_rdata, 32'd0);
        check("to_errcnt", 32'(error_count), 32'd1);
        check("to_mm_valid", 32'(mm_valid), 32'd0);
        req_valid = 4'b1001;
        cyc(1);
        check("to_ready_clear", 32'(req_ready), 32'd0);
        check("to_error_clear", 32'(req_error), 32'd0);
        cyc(1);
        check("to_lock_dropped", 32'(grant_id), 32'd0);
        cyc(1);
        man_ready = 1'b1;
        cyc(1);
        check("to_next_ready", 32'(req_ready), 32'b0001);
        check("to_errcnt_hold", 32'(error_count), 32'd1);
        req_valid = 4'b1000;
        req_lock  = '0;
        man_ready = 1'b0;
        cyc(2);

        // Requester 3 again, ack exactly on the 8th ISSUE edge: normal completion
        check("ack8_grant", 32'(grant_id), 32'd3);
        cyc(7);
        check("ack8_ready_early", 32'(req_ready), 32'd0);
        man_ready = 1'b1;
        mm_rdata  = 32'hCAFEF00D;
        cyc(1);
        check("ack8_ready", 32'(req_ready), 32'b1000);
        check("ack8_error", 32'(req_error), 32'd0);
        check("ack8_rdata", req_rdata, 32'hCAFEF00D);
        check("ack8_errcnt", 32'(error_count), 32'd1);
        man_ready = 1'b0;
        req_valid = '0;
        cyc(1);
        check("ack8_busy_low", 32'(busy), 32'd0);

        // Lock: requester 1 holds three grants with 0 and 2 waiting, then 2, 0
        auto_ack  = 1'b1;
        req_valid = 4'b0010;
        req_lock  = 4'b0010;
        req_write = 4'b1111;
        req_addr[1*AW +: AW] = 12'h111;
        cyc(1);
        check("lk_grant0", 32'(grant_id), 32'd1);
        check("lk_addr", 32'(mm_addr), 32'h111);
        req_valid = 4'b0111;
        next_grant(gap);
        check("lk_gap1", 32'(gap), 32'd4);
        check("lk_grant1", 32'(grant_id), 32'd1);
        next_grant(gap);
        check("lk_gap2", 32'(gap), 32'd4);
        check("lk_grant2", 32'(grant_id), 32'd1);
        req_lock = '0;
        next_grant(gap);
        check("lk_grant3", 32'(grant_id), 32'd2);
        next_grant(gap);
        check("lk_grant4", 32'(grant_id), 32'd0);

        // Reset in the middle of ISSUE
        auto_ack  = 1'b0;
        req_valid = 4'b1111;
        cyc(1);
        reset_n = 1'b0;
        #1;
        check("mr_mm_valid", 32'(mm_valid), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_ready", 32'(req_ready), 32'd0);
        cyc(1);
        check("mr_ready_hold", 32'(req_ready), 32'd0);
        check("mr_errcnt", 32'(error_count), 32'd0);
        reset_n  = 1'b1;
        auto_ack = 1'b1;

        // Round robin with all four requesting after reset: 0,1,2,3,0,1
        cyc(1);
        check("rr_grant_first", 32'(grant_id), 32'd0);
        check("rr_mm_valid", 32'(mm_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            next_grant(gap);
            check("rr_gap", 32'(gap), 32'd4);
            check("rr_grant", 32'(grant_id), 32'((i + 1) % 4));
        end
        check("rr_errcnt", 32'(error_count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
